// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
  logic        req0;
  logic [31:0] addr0;
  logic        req1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        we1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, addr0, req1, addr1, wdata1, we1, mem_rdata,
    output ack0, ack1, rdata, mem_sel, mem_addr, mem_wdata, mem_en, mem_we
  );

  modport master (
    output req0, addr0, req1, addr1, wdata1, we1, mem_rdata,
    input  ack0, ack1, rdata, mem_sel, mem_addr, mem_wdata, mem_en, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (port 0) and load/store (port 1), round-robin on ties.
// Optional macro ARB_DATA_PRIO_EN: port 1 wins every tie and no last-grant history is kept.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | nothing in flight; pending requests are arbitrated here
  // ACCESS | memory enabled; cnt counts down to the final access cycle
  // ACK    | one-cycle completion pulse to the granted port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel;
  logic             sel_nxt;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_nxt;
  logic             tie_pick;
  logic             store_now;
  logic             unused_addr_lsbs;

`ifdef ARB_DATA_PRIO_EN
  assign tie_pick = 1'b1;
`else
  logic last_gnt;

  // Port 0 wins the first tie because last_gnt comes out of reset pointing at port 1.
  assign tie_pick = ~last_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && bus.req0 && bus.req1) begin
      last_gnt <= tie_pick;
    end
  end
`endif

  assign store_now = sel & bus.we1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    rdata_nxt = rdata_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = ACCESS;
          cnt_nxt   = LAT_M1;
          if (bus.req0 && bus.req1) begin
            sel_nxt = tie_pick;
          end else begin
            sel_nxt = bus.req1;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nxt = ACK;
          if (!store_now) begin
            rdata_nxt = bus.mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel     <= sel_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  // Address low bits are dropped by the word-aligning mux; no misalignment check.
  assign unused_addr_lsbs = ^{bus.addr0[1:0], bus.addr1[1:0]};

  assign bus.ack0      = (state == ACK) && !sel;
  assign bus.ack1      = (state == ACK) && sel;
  assign bus.rdata     = rdata_q;
  assign bus.mem_sel   = sel;
  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && store_now;
  assign bus.mem_addr  = sel ? {bus.addr1[31:2], 2'b00} : {bus.addr0[31:2], 2'b00};
  assign bus.mem_wdata = sel ? bus.wdata1 : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a timing model.
// Two instances (MEM_LAT=2 and MEM_LAT=1) share the same stimulus.
module tb_mem_port_arbiter;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        r0, r1, we;
  logic [31:0] a0, a1, wd, mrd;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LAT(LAT0), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  mem_port_arbiter #(.MEM_LAT(LAT1), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  assign bus_a.req0 = r0;  assign bus_a.addr0 = a0;  assign bus_a.req1 = r1;
  assign bus_a.addr1 = a1; assign bus_a.wdata1 = wd; assign bus_a.we1 = we;
  assign bus_a.mem_rdata = mrd;
  assign bus_b.req0 = r0;  assign bus_b.addr0 = a0;  assign bus_b.req1 = r1;
  assign bus_b.addr1 = a1; assign bus_b.wdata1 = wd; assign bus_b.we1 = we;
  assign bus_b.mem_rdata = mrd;

  logic [1:0]       o_ack0, o_ack1, o_en, o_we, o_sel;
  logic [1:0][31:0] o_rd, o_addr, o_wd;
  assign o_ack0 = {bus_b.ack0, bus_a.ack0};
  assign o_ack1 = {bus_b.ack1, bus_a.ack1};
  assign o_en   = {bus_b.mem_en, bus_a.mem_en};
  assign o_we   = {bus_b.mem_we, bus_a.mem_we};
  assign o_sel  = {bus_b.mem_sel, bus_a.mem_sel};
  assign o_rd   = {bus_b.rdata, bus_a.rdata};
  assign o_addr = {bus_b.mem_addr, bus_a.mem_addr};
  assign o_wd   = {bus_b.mem_wdata, bus_a.mem_wdata};

  int vectors = 0;
  int miscompares = 0;

  // Transaction-timing model: a grant at edge g means access cycles g+1..g+L, ack in cycle g+L+1,
  // and the next grant no earlier than edge g+L+2. e is the index of the next edge (= current cycle).
  int          e;
  bit          m_busy[2];
  int          m_g[2];
  bit          m_sel[2];
  bit          m_last[2];
  logic [31:0] m_rd[2];
  logic [31:0] last_load;

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = (k == 1) ? LAT1 : LAT0;
      if (reset) begin
        m_busy[k] = 1'b0;
        m_sel[k]  = 1'b0;
        m_last[k] = 1'b1;
        m_rd[k]   = '0;
      end else begin
        if (m_busy[k] && e == m_g[k] + lat && !(m_sel[k] && we)) m_rd[k] = mrd;
        if (!m_busy[k] || e >= m_g[k] + lat + 2) begin
          m_busy[k] = 1'b0;
          if (r0 || r1) begin
            m_busy[k] = 1'b1;
            m_g[k]    = e;
            if (r0 && r1) begin
`ifdef ARB_DATA_PRIO_EN
              m_sel[k] = 1'b1;
`else
              m_sel[k]  = ~m_last[k];
              m_last[k] = m_sel[k];
`endif
            end else begin
              m_sel[k] = r1;
            end
          end
        end
      end
    end
    e++;
    #1;
  endtask

  function automatic logic [4:0] x_ctl(int k);
    int lat;
    bit acc, ackc;
    lat  = (k == 1) ? LAT1 : LAT0;
    acc  = m_busy[k] && (e >= m_g[k] + 1) && (e <= m_g[k] + lat);
    ackc = m_busy[k] && (e == m_g[k] + lat + 1);
    return {ackc && !m_sel[k], ackc && m_sel[k], acc, acc && m_sel[k] && we, m_sel[k]};
  endfunction

  task automatic do_reset();
    r0 = 0; r1 = 0; we = 0; a0 = '0; a1 = '0; wd = '0; mrd = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = 0;
  endtask

  task automatic test_reset();
    r0 = 0; r1 = 0; we = 0; a0 = '0; a1 = '0; wd = '0; mrd = 32'hFFFF_FFFF;
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({o_ack0[k], o_ack1[k], o_en[k], o_we[k], o_sel[k]} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_ctl dut%0d got %b expected 00000", k, {o_ack0[k], o_ack1[k], o_en[k], o_we[k], o_sel[k]});
      end
      vectors++;
      if (o_rd[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata dut%0d got %h expected 0", k, o_rd[k]);
      end
    end
    reset = 1'b0;
    e = 0;
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] cap;
    logic [3:0]  xv;
    cap = '0;
    do_reset();
    r0 = 1; a0 = 32'h0000_0040;
    for (int c = 0; c <= 4; c++) begin
      mrd = $urandom;
      if (c == 2) cap = mrd;
      @(negedge clk);
      xv = (c == 1 || c == 2) ? 4'b0010 : (c == 3) ? 4'b1000 : 4'b0000;
      vectors++;
      if ({o_ack0[0], o_ack1[0], o_en[0], o_sel[0]} !== xv) begin
        miscompares++;
        $display("FAIL fetch_ctl c=%0d got %b expected %b", c, {o_ack0[0], o_ack1[0], o_en[0], o_sel[0]}, xv);
      end
      if (c == 1 || c == 2) begin
        vectors++;
        if (o_addr[0] !== 32'h0000_0040) begin
          miscompares++;
          $display("FAIL fetch_addr c=%0d got %h expected 00000040", c, o_addr[0]);
        end
      end
      if (c == 3) begin
        vectors++;
        if (o_rd[0] !== cap) begin
          miscompares++;
          $display("FAIL fetch_rdata got %h expected %h", o_rd[0], cap);
        end
        r0 = 0;
      end
      tick();
    end
    last_load = cap;
  endtask

  task automatic test_store();
    logic [4:0] xv;
    r1 = 1; we = 1; a1 = 32'h1000_0007; wd = 32'hDEAD_BEEF;
    for (int c = 0; c <= 4; c++) begin
      mrd = $urandom | 32'h1;
      @(negedge clk);
      xv = (c == 1 || c == 2) ? 5'b00111 : (c == 3) ? 5'b01001 : (c == 4) ? 5'b00001 : 5'b00000;
      vectors++;
      if ({o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]} !== xv) begin
        miscompares++;
        $display("FAIL store_ctl c=%0d got %b expected %b", c, {o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]}, xv);
      end
      if (c == 1 || c == 2) begin
        vectors++;
        if (o_addr[0] !== 32'h1000_0004 || o_wd[0] !== 32'hDEAD_BEEF) begin
          miscompares++;
          $display("FAIL store_bus c=%0d got addr %h wdata %h expected 10000004 deadbeef", c, o_addr[0], o_wd[0]);
        end
      end
      if (c == 3) begin
        vectors++;
        if (o_rd[0] !== last_load) begin
          miscompares++;
          $display("FAIL store_rdata got %h expected %h", o_rd[0], last_load);
        end
        r1 = 0; we = 0;
      end
      tick();
    end
  endtask

  task automatic test_tie();
    logic [1:0] xv;
    do_reset();
    r0 = 1; r1 = 1; we = 0; a0 = 32'h100; a1 = 32'h200;
    for (int c = 0; c <= 16; c++) begin
      mrd = $urandom;
      @(negedge clk);
      xv = 2'b00;
      if (c >= 3 && (c - 3) % 4 == 0 && c <= 15) begin
`ifdef ARB_DATA_PRIO_EN
        xv = 2'b01;
`else
        xv = (((c - 3) / 4) % 2 == 0) ? 2'b10 : 2'b01;
`endif
      end
      vectors++;
      if ({o_ack0[0], o_ack1[0]} !== xv) begin
        miscompares++;
        $display("FAIL tie_ack c=%0d got ack0/ack1 %b expected %b", c, {o_ack0[0], o_ack1[0]}, xv);
      end
      tick();
    end
    r0 = 0; r1 = 0;
  endtask

  task automatic test_drop();
    logic [1:0] xv;
    do_reset();
    r0 = 1; a0 = 32'h80;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      xv = (c == 1 || c == 2) ? 2'b01 : (c == 3) ? 2'b10 : 2'b00;
      vectors++;
      if ({o_ack0[0], o_en[0]} !== xv) begin
        miscompares++;
        $display("FAIL drop_ctl c=%0d got ack0/en %b expected %b", c, {o_ack0[0], o_en[0]}, xv);
      end
      if (c == 1) r0 = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] xv;
    do_reset();
    r1 = 1; we = 1; a1 = 32'h2000_0000; wd = 32'h1234_5678;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if ({o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]} !== 5'b00111) begin
      miscompares++;
      $display("FAIL rstmid_pre got %b expected 00111", {o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; r0 = 1; a0 = 32'h300;
    @(negedge clk);
    vectors++;
    if ({o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]} !== 5'b00000) begin
      miscompares++;
      $display("FAIL rstmid_post got %b expected 00000", {o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]});
    end
    tick();
    @(negedge clk);
`ifdef ARB_DATA_PRIO_EN
    xv = 5'b00111;
`else
    xv = 5'b00100;
`endif
    vectors++;
    if ({o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]} !== xv) begin
      miscompares++;
      $display("FAIL rstmid_regrant got %b expected %b", {o_ack0[0], o_ack1[0], o_en[0], o_we[0], o_sel[0]}, xv);
    end
    tick();
    tick();
    @(negedge clk);
    vectors++;
`ifdef ARB_DATA_PRIO_EN
    if ({o_ack0[0], o_ack1[0]} !== 2'b01) begin
`else
    if ({o_ack0[0], o_ack1[0]} !== 2'b10) begin
`endif
      miscompares++;
      $display("FAIL rstmid_ack got ack0/ack1 %b", {o_ack0[0], o_ack1[0]});
    end
    r0 = 0; r1 = 0; we = 0;
    tick();
  endtask

  task automatic test_lat1();
    logic [31:0] cap;
    logic [1:0]  xv;
    cap = '0;
    do_reset();
    r1 = 1; we = 0; a1 = 32'h400;
    for (int c = 0; c <= 9; c++) begin
      mrd = $urandom;
      if (c == 1 || c == 4 || c == 7) cap = mrd;
      @(negedge clk);
      xv = (c == 2 || c == 5 || c == 8) ? 2'b10 : (c == 1 || c == 4 || c == 7) ? 2'b01 : 2'b00;
      vectors++;
      if ({o_ack1[1], o_en[1]} !== xv) begin
        miscompares++;
        $display("FAIL lat1_ctl c=%0d got ack1/en %b expected %b", c, {o_ack1[1], o_en[1]}, xv);
      end
      if (c == 2 || c == 5 || c == 8) begin
        vectors++;
        if (o_rd[1] !== cap) begin
          miscompares++;
          $display("FAIL lat1_rdata c=%0d got %h expected %h", c, o_rd[1], cap);
        end
      end
      if (c == 8) r1 = 0;
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      r0  = ($urandom_range(0, 2) != 0);
      r1  = ($urandom_range(0, 2) != 0);
      we  = $urandom_range(0, 1);
      a0  = $urandom; a1 = $urandom; wd = $urandom; mrd = $urandom;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({o_ack0[k], o_ack1[k], o_en[k], o_we[k], o_sel[k]} !== x_ctl(k)) begin
          miscompares++;
          $display("FAIL rnd_ctl dut%0d i=%0d got %b expected %b", k, i,
                   {o_ack0[k], o_ack1[k], o_en[k], o_we[k], o_sel[k]}, x_ctl(k));
        end
        vectors++;
        if (o_addr[k] !== (m_sel[k] ? {a1[31:2], 2'b00} : {a0[31:2], 2'b00})) begin
          miscompares++;
          $display("FAIL rnd_addr dut%0d i=%0d got %h", k, i, o_addr[k]);
        end
        vectors++;
        if (o_wd[k] !== (m_sel[k] ? wd : 32'h0)) begin
          miscompares++;
          $display("FAIL rnd_wdata dut%0d i=%0d got %h", k, i, o_wd[k]);
        end
        vectors++;
        if (o_rd[k] !== m_rd[k]) begin
          miscompares++;
          $display("FAIL rnd_rdata dut%0d i=%0d got %h expected %h", k, i, o_rd[k], m_rd[k]);
        end
      end
      tick();
    end
    reset = 1'b0; r0 = 0; r1 = 0; we = 0;
  endtask

  initial begin
    reset = 1'b1;
    e = 0;
    last_load = '0;
    test_reset();
    test_fetch();
    test_store();
    test_tie();
    test_drop();
    test_reset_mid();
    test_lat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Runs a req/ack handshake per requester and arbitrates round-robin.
- Drives the select of the existing 32-bit 2:1 muxes that steer address and write data onto the memory port.
- Sequences each access over a fixed memory latency and returns registered read data.

Parameters:
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must hold MEM_LAT-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  fetch request; held high until ack0.
- addr0  input  32  fetch address; stable while req0 is high.
- req1  input  1  load/store request; held high until ack1.
- addr1  input  32  data address; stable while req1 is high.
- wdata1  input  32  store data.
- we1  input  1  1 = store, 0 = load.
- ack0  output  1  one-cycle completion pulse for port 0.
- ack1  output  1  one-cycle completion pulse for port 1.
- rdata  output  32  registered read data; valid only in an ack cycle.
- mem_sel  output  1  mux select (0 = port 0, 1 = port 1); feeds the address and wdata 32-bit 2:1 muxes.
- mem_addr  output  32  word-aligned muxed address, {addr[31:2],2'b00}.
- mem_wdata  output  32  muxed write data; port 0 contributes 32'h0.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_rdata  input  32  memory read data; valid in the final ACCESS cycle.

Behaviour:
- Reset values: ack0=0, ack1=0, rdata=0, mem_sel=0, mem_en=0, mem_we=0, FSM=IDLE, cnt=0, last_gnt=1. With last_gnt=1, port 0 wins the first tie.
- FSM states: IDLE, ACCESS, ACK.
- IDLE, no request: stay in IDLE; mem_en=0.
- IDLE, exactly one req: grant that port; mem_sel <= port index; cnt <= MEM_LAT-1; go to ACCESS.
- IDLE, both req: grant the port != last_gnt; last_gnt <= granted port.
- ACCESS:
  - mem_en=1.
  - mem_we = (mem_sel==1) & we1.
  - Decrement cnt each cycle.
  - When cnt==0: rdata <= mem_rdata (loads only; stores leave rdata unchanged); go to ACK.
- ACK: ack[mem_sel]=1 for exactly one cycle; mem_en=0; return to IDLE.
- mem_sel holds its value through ACCESS and ACK and changes only on a grant.
- mem_addr and mem_wdata are combinational from mem_sel through the 2:1 muxes.
- Latency: a req sampled in IDLE at edge N gives ACCESS for cycles N+1..N+MEM_LAT and ack at cycle N+MEM_LAT+1.
- Minimum spacing between grants: MEM_LAT+2 cycles, because IDLE is always visited.
- A requester that still holds req in the cycle after its ack is treated as a new request.
- Req dropped mid-ACCESS: the access still completes and ack still pulses; the requester ignores it.
- A req raised during ACCESS/ACK waits; it is evaluated in the next IDLE.
- Reset mid-ACCESS: at the next edge, all outputs take reset values; no ack is issued; the memory write is abandoned.
- addr[1:0] are ignored; no misalignment error is reported.

Optional Feature:
- ARB_DATA_PRIO_EN
- Defined: on a tie, port 1 (load/store) always wins; last_gnt is not used.
- Undefined: round-robin as described above.

Test Plan:
- Fetch only, MEM_LAT=2: req0=1, addr0=32'h0000_0040 at edge 0 -> mem_sel=0, mem_en=1 at cycles 1-2, mem_addr=32'h40; ack0 at cycle 3; rdata equals mem_rdata sampled at cycle 2.
- Store: req1=1, we1=1, addr1=32'h1000_0007, wdata1=32'hDEAD_BEEF -> mem_sel=1, mem_we=1 for 2 cycles, mem_addr=32'h1000_0004, mem_wdata=32'hDEAD_BEEF; ack1 one cycle; rdata unchanged.
- Both ports held high continuously, starting from reset -> grant order 0,1,0,1; acks at cycles 3,7,11,15. With ARB_DATA_PRIO_EN -> port 1 granted every time, and port 0 is starved.
- Req0 dropped in the first ACCESS cycle -> access runs to completion; ack0 still pulses at cycle 3.
- Reset asserted in the 2nd ACCESS cycle of a store -> next cycle mem_en=0, mem_we=0, mem_sel=0; no ack; a fresh req0 then wins the tie against req1.
- MEM_LAT=1: single load -> one ACCESS cycle; ack at cycle 2; back-to-back loads acked at cycles 2,5,8.
